// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: stage FSM encoding, per-boundary payload
// layouts and the no-op bubble each boundary drives when empty or flushed.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  alu_b_sel;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  // Bubbles must be architectural no-ops: no writeback, no memory access.
  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: 32'h0000_0013};

  localparam id_ex_t ID_EX_BUBBLE = '{pc: 32'h0, rs1_val: 32'h0, rs2_val: 32'h0,
                                      imm: 32'h0, rd: 5'd0, alu_op: 4'd0,
                                      alu_b_sel: 2'b01, reg_we: 1'b0,
                                      mem_re: 1'b0, mem_we: 1'b0};

  localparam ex_mem_t EX_MEM_BUBBLE = '{alu_res: 32'h0, st_data: 32'h0, rd: 5'd0,
                                        reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0};

  localparam mem_wb_t MEM_WB_BUBBLE = '{wb_data: 32'h0, rd: 5'd0, reg_we: 1'b0};

endpackage

// File: rtl/pipe_cnt_sat.sv
// Saturating event counter for the performance-monitor taps; clear beats
// increment so a coincident clear always reads back zero.
module pipe_cnt_sat
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush bubble,
// optional skid entry (registered in_ready) and stall/flush perf counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int unsigned       SKID       = 0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  input  logic              cnt_clr
);

  logic              in_fire, out_fire, skid_vld;
  logic [DATA_W-1:0] main_q, main_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) main_q <= BUBBLE_VAL;
    else     main_q <= main_d;
  end

  if (SKID == 0) begin : g_single
    logic vld_q, vld_d;

    // A stall (neither handshake) falls through and keeps main_q intact.
    always_comb begin
      vld_d  = vld_q;
      main_d = main_q;
      if (flush) begin
        vld_d  = 1'b0;
        main_d = BUBBLE_VAL;
      end else if (in_fire) begin
        vld_d  = 1'b1;
        main_d = in_data;
      end else if (out_fire) begin
        vld_d  = 1'b0;
        main_d = BUBBLE_VAL;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;
    end

    assign out_valid = vld_q;
    assign skid_vld  = 1'b0;
    assign in_ready  = ~flush & (~vld_q | out_ready);

  end else begin : g_skid
    stage_e            state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        skid_q  <= BUBBLE_VAL;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        skid_q  <= skid_d;
        rdy_q   <= (state_d != ST_FULL);
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
      end else begin
        case (state_q)
          ST_EMPTY: if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
          ST_BUSY: begin
            if (in_fire && !out_fire) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else if (out_fire && !in_fire) begin
              state_d = ST_EMPTY;
              main_d  = BUBBLE_VAL;
            end else if (in_fire && out_fire) begin
              main_d  = in_data;
            end
          end
          // Skid only ever refills main, so order stays FIFO.
          ST_FULL: if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    always_comb begin
      out_valid = (state_q != ST_EMPTY);
      skid_vld  = (state_q == ST_FULL);
      in_ready  = rdy_q & ~flush;
    end

    a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
      state_q == ST_FULL |-> !in_ready);
  end

  pipe_cnt_sat #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(out_valid & ~out_ready),
    .clr_i(cnt_clr),
    .cnt_o(stall_cnt)
  );

  pipe_cnt_sat #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(flush & (out_valid | skid_vld)),
    .clr_i(cnt_clr),
    .cnt_o(flush_cnt)
  );

  a_bubble: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> out_data == BUBBLE_VAL);
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid & ~out_ready & ~flush) |=> $stable(out_data));

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces the per-boundary hand-written stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload with a valid/ready handshake.
- Stall holds the current contents. Flush inserts a configurable bubble pattern.
- An optional skid entry registers the upstream ready path. Saturating stall and flush counters feed the performance-monitor taps.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload driven while the stage is empty or flushed. Per-boundary no-op controls (e.g. ALU operand-B select = 2'b01) are set here.
- SKID, 0, 0 = single entry with combinational in_ready; 1 = two entries (main + skid) with registered in_ready.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries (branch/jump redirect)
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload at output is a real instruction
- out_ready  in  1  downstream accepts (0 = stall/hazard hold)
- out_data  out  DATA_W  registered payload; equals BUBBLE_VAL whenever out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  flushes that discarded at least one valid entry, saturating
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=BUBBLE_VAL, skid entry invalid.
  - stall_cnt=0, flush_cnt=0.
  - in_ready=1 (SKID=1), or follows the SKID=0 equation below.
- Transfer rules:
  - Input handshake fires when in_valid & in_ready.
  - Output handshake fires when out_valid & out_ready.
  - Latency is 1 cycle from input handshake to out_valid when the stage is empty.
- SKID=0:
  - in_ready = ~out_valid | out_ready. This path is combinational through out_ready.
  - On input handshake: out_data<=in_data, out_valid<=1.
  - On output handshake with no input: out_valid<=0, out_data<=BUBBLE_VAL.
  - On neither: hold. A stall never alters out_data. This is the key fix over the old pause-clears behaviour.
- SKID=1: state machine with three states.
  - EMPTY: main invalid. Input handshake -> BUSY.
  - BUSY: main valid, skid invalid.
    - Input without output -> FULL (in_data captured into skid).
    - Output without input -> EMPTY.
    - Both -> BUSY (main<=in_data).
  - FULL: main and skid valid.
    - in_ready=0.
    - Output handshake -> BUSY (main<=skid).
  - in_ready is a flop, =1 in EMPTY and BUSY, =0 in FULL. It carries no combinational path from out_ready.
  - Ordering is strictly FIFO: the skid entry never overtakes main.
- Flush (highest priority, either mode):
  - Next cycle: out_valid=0, out_data=BUBBLE_VAL, skid invalid, state EMPTY.
  - in_ready is forced 0 during the flush cycle. The payload presented that cycle is dropped and the input handshake does not fire.
  - An output handshake in the flush cycle still counts as delivered downstream.
- flush coincident with rst: rst wins.
- Counters:
  - stall_cnt +1 per cycle with out_valid & ~out_ready.
  - flush_cnt +1 per flush cycle in which out_valid or skid-valid is 1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr zeroes both. If cnt_clr and an increment coincide, the result is 0.
- Reset mid-transfer: all held payload is discarded and no partial state survives.
- SVA hooks:
  - out_valid=0 -> out_data==BUBBLE_VAL.
  - out_data stable while out_valid & ~out_ready & ~flush.
  - in_ready=0 in FULL.

Decomposition:
- Shared package pipe_pkg:
  - Stage state enum (ST_EMPTY, ST_BUSY, ST_FULL).
  - Per-boundary bubble constants (ID_EX_BUBBLE, EX_MEM_BUBBLE, ...).
  - Payload packed-struct typedefs, so the top level packs and unpacks the former discrete fields.
- One sub-module: pipe_cnt_sat, a CNT_W saturating counter with inc and clr, instantiated twice.

Test Plan:
- Reset then idle, DATA_W=8, BUBBLE_VAL=8'h40 -> out_valid=0, out_data=8'h40, in_ready=1, counters 0.
- SKID=0, stream 8'h01..8'h05 with out_ready=1 -> out_data matches each value 1 cycle later, no gaps, stall_cnt=0.
- SKID=1, send 8'hA1, 8'hA2 with out_ready=0 for 4 cycles, then 1 -> in_ready=0 after second accept; stall_cnt=4; outputs A1 then A2 in order; in_ready back to 1.
- Flush in FULL state with in_valid=1, in_data=8'hFF -> next cycle out_valid=0, out_data=8'h40, 8'hFF never appears, flush_cnt=1. A second flush when empty leaves flush_cnt=1.
- CNT_W=3, hold a stall for 10 cycles -> stall_cnt sticks at 7; cnt_clr pulse -> 0.
- Assert rst mid-stall with both entries valid -> out_valid drops asynchronously, out_data=8'h40, and neither held payload ever appears after release.
